// File: rtl/instr_encoder_loader_pkg.sv
// Shared types and encoding constants for the RV32I instruction encoder/loader.
package instr_enc_pkg;

  // Mnemonic codes on the input stream; codes 21..31 are illegal.
  typedef enum logic [4:0] {
    OpAdd, OpSub, OpAnd, OpOr, OpXor, OpSll, OpSrl, OpSra,
    OpAddi, OpAndi, OpOri, OpXori, OpSlli, OpSrli, OpSrai,
    OpLw, OpSw, OpBeq, OpBne, OpJal, OpJalr
  } op_e;

  typedef enum logic [1:0] {StIdle, StLoad, StFlush, StDone} state_e;

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;

  localparam logic [2:0] F3Add  = 3'b000;
  localparam logic [2:0] F3Sll  = 3'b001;
  localparam logic [2:0] F3Xor  = 3'b100;
  localparam logic [2:0] F3Srl  = 3'b101;
  localparam logic [2:0] F3Or   = 3'b110;
  localparam logic [2:0] F3And  = 3'b111;
  localparam logic [2:0] F3Word = 3'b010;
  localparam logic [2:0] F3Beq  = 3'b000;
  localparam logic [2:0] F3Bne  = 3'b001;
  localparam logic [2:0] F3Jalr = 3'b000;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;

  localparam logic [31:0] NOP_WORD = 32'h00000013;

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Instruction stream in / instruction-memory write bus out of the loader.
interface instr_encoder_loader_if #(
  parameter int unsigned ADDR_W = 8
) ();
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_op;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [31:0]       in_imm;
  logic              in_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  // Host / program source side.
  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_last,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  // Loader side.
  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_last,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/rv32_encode.sv
// Combinational RV32I encoder: symbolic instruction -> 32-bit word plus a bad flag.
// Optional ENC_RANGE_CHECK_EN: out-of-range immediates yield NOP with bad set;
// otherwise immediates are truncated to their field.
module rv32_encode
  import instr_enc_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        bad
);

  op_e  op_c;
  logic i_ok, sh_ok, b_ok, j_ok, imm_ok;

  assign op_c = op_e'(op);

`ifdef ENC_RANGE_CHECK_EN
  logic signed [31:0] simm;
  assign simm  = signed'(imm);
  assign i_ok  = (simm >= -2048) && (simm <= 2047);
  assign sh_ok = (simm >= 0) && (simm <= 31);
  assign b_ok  = (simm >= -4096) && (simm <= 4094) && !imm[0];
  assign j_ok  = (simm >= -(2 ** 20)) && (simm <= (2 ** 20) - 2) && !imm[0];
`else
  logic unused_imm;
  assign unused_imm = ^{imm[31:21], imm[0]};
  assign i_ok  = 1'b1;
  assign sh_ok = 1'b1;
  assign b_ok  = 1'b1;
  assign j_ok  = 1'b1;
`endif

  // Field assembly per format; any rejected op or immediate collapses to NOP.
  always_comb begin
    word   = NOP_WORD;
    imm_ok = 1'b1;
    bad    = 1'b0;
    case (op_c)
      OpAdd:  word = {F7Base, rs2, rs1, F3Add, rd, OpcOp};
      OpSub:  word = {F7Alt,  rs2, rs1, F3Add, rd, OpcOp};
      OpAnd:  word = {F7Base, rs2, rs1, F3And, rd, OpcOp};
      OpOr:   word = {F7Base, rs2, rs1, F3Or,  rd, OpcOp};
      OpXor:  word = {F7Base, rs2, rs1, F3Xor, rd, OpcOp};
      OpSll:  word = {F7Base, rs2, rs1, F3Sll, rd, OpcOp};
      OpSrl:  word = {F7Base, rs2, rs1, F3Srl, rd, OpcOp};
      OpSra:  word = {F7Alt,  rs2, rs1, F3Srl, rd, OpcOp};
      OpAddi: begin word = {imm[11:0], rs1, F3Add, rd, OpcOpImm}; imm_ok = i_ok; end
      OpAndi: begin word = {imm[11:0], rs1, F3And, rd, OpcOpImm}; imm_ok = i_ok; end
      OpOri:  begin word = {imm[11:0], rs1, F3Or,  rd, OpcOpImm}; imm_ok = i_ok; end
      OpXori: begin word = {imm[11:0], rs1, F3Xor, rd, OpcOpImm}; imm_ok = i_ok; end
      OpSlli: begin word = {F7Base, imm[4:0], rs1, F3Sll, rd, OpcOpImm}; imm_ok = sh_ok; end
      OpSrli: begin word = {F7Base, imm[4:0], rs1, F3Srl, rd, OpcOpImm}; imm_ok = sh_ok; end
      OpSrai: begin word = {F7Alt,  imm[4:0], rs1, F3Srl, rd, OpcOpImm}; imm_ok = sh_ok; end
      OpLw:   begin word = {imm[11:0], rs1, F3Word, rd, OpcLoad}; imm_ok = i_ok; end
      OpSw: begin
        word   = {imm[11:5], rs2, rs1, F3Word, imm[4:0], OpcStore};
        imm_ok = i_ok;
      end
      OpBeq: begin
        word   = {imm[12], imm[10:5], rs2, rs1, F3Beq, imm[4:1], imm[11], OpcBranch};
        imm_ok = b_ok;
      end
      OpBne: begin
        word   = {imm[12], imm[10:5], rs2, rs1, F3Bne, imm[4:1], imm[11], OpcBranch};
        imm_ok = b_ok;
      end
      OpJal: begin
        word   = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OpcJal};
        imm_ok = j_ok;
      end
      OpJalr: begin word = {imm[11:0], rs1, F3Jalr, rd, OpcJalr}; imm_ok = i_ok; end
      default: imm_ok = 1'b0;
    endcase
    if (!imm_ok) begin
      word = NOP_WORD;
      bad  = 1'b1;
    end
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Streams symbolic RV32I instructions in, encodes them and writes them to consecutive
// instruction-memory word addresses starting at BASE_ADDR after each start pulse.
// Optional ENC_RANGE_CHECK_EN (see rv32_encode) range-checks immediates.
module instr_encoder_loader
  import instr_enc_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  instr_encoder_loader_if.slave bus,
  output logic [ADDR_W:0]       count,
  output logic                  done,
  output logic                  err
);

  localparam logic [ADDR_W-1:0] BaseAddr = BASE_ADDR[ADDR_W-1:0];
  localparam logic [ADDR_W:0]   CountMax = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q, state_d;
  logic              in_ready, accept, full;
  logic [31:0]       enc_word;
  logic              enc_bad;
  logic [ADDR_W-1:0] wptr_q, wptr_d, addr_q, addr_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;

  rv32_encode u_encode (
    .op   (bus.in_op),
    .rd   (bus.in_rd),
    .rs1  (bus.in_rs1),
    .rs2  (bus.in_rs2),
    .imm  (bus.in_imm),
    .word (enc_word),
    .bad  (enc_bad)
  );

  assign accept = bus.in_valid && in_ready;
  // Accepting at the top address leaves no room for a following word.
  assign full   = (wptr_q == {ADDR_W{1'b1}});

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // FSM next state: start overrides everything; the last (or forced-last) accept flushes.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = StLoad;
    end else begin
      unique case (state_q)
        StIdle:  state_d = StIdle;
        StLoad:  if (accept && (bus.in_last || full)) state_d = StFlush;
        StFlush: state_d = StDone;
        StDone:  state_d = StDone;
        default: state_d = StIdle;
      endcase
    end
  end

  // FSM outputs.
  always_comb begin
    in_ready = (state_q == StLoad) && !start;
    done     = (state_q == StDone);
  end

  // Datapath next state: a write already registered still completes across a start.
  always_comb begin
    wptr_d  = wptr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = accept;
    count_d = count_q;
    err_d   = err_q;
    if (start) begin
      wptr_d  = BaseAddr;
      count_d = '0;
      err_d   = 1'b0;
    end else begin
      if (we_q && (count_q != CountMax)) count_d = count_q + (ADDR_W + 1)'(1);
      if (accept) begin
        wptr_d  = wptr_q + ADDR_W'(1);
        addr_d  = wptr_q;
        wdata_d = enc_word;
        if (enc_bad || (full && !bus.in_last)) err_d = 1'b1;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= BaseAddr;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign count         = count_q;
  assign err           = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench: two loaders (ADDR_W=8 and ADDR_W=2) share one random stimulus
// stream; each is compared every cycle against a behavioural model.
module tb_instr_encoder_loader;
  import instr_enc_pkg::*;

  logic clk = 1'b0;
  logic reset, start;
  always #5 clk = ~clk;

  logic        valid, last;
  logic [4:0]  op, rd, rs1, rs2;
  logic [31:0] imm;

  instr_encoder_loader_if #(.ADDR_W(8)) bus0 ();
  instr_encoder_loader_if #(.ADDR_W(2)) bus1 ();

  logic [8:0] cnt0;
  logic [2:0] cnt1;
  logic       done0, done1, err0, err1;

  assign bus0.in_valid = valid;
  assign bus0.in_op    = op;
  assign bus0.in_rd    = rd;
  assign bus0.in_rs1   = rs1;
  assign bus0.in_rs2   = rs2;
  assign bus0.in_imm   = imm;
  assign bus0.in_last  = last;
  assign bus1.in_valid = valid;
  assign bus1.in_op    = op;
  assign bus1.in_rd    = rd;
  assign bus1.in_rs1   = rs1;
  assign bus1.in_rs2   = rs2;
  assign bus1.in_imm   = imm;
  assign bus1.in_last  = last;

  instr_encoder_loader #(.ADDR_W(8), .BASE_ADDR(0)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bus   (bus0.slave),
    .count (cnt0),
    .done  (done0),
    .err   (err0)
  );

  instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bus   (bus1.slave),
    .count (cnt1),
    .done  (done1),
    .err   (err1)
  );

  logic        o_we[2], o_done[2], o_err[2], o_rdy[2];
  logic [31:0] o_addr[2], o_data[2], o_cnt[2];
  assign o_we[0]   = bus0.mem_we;
  assign o_we[1]   = bus1.mem_we;
  assign o_addr[0] = 32'(bus0.mem_addr);
  assign o_addr[1] = 32'(bus1.mem_addr);
  assign o_data[0] = bus0.mem_wdata;
  assign o_data[1] = bus1.mem_wdata;
  assign o_cnt[0]  = 32'(cnt0);
  assign o_cnt[1]  = 32'(cnt1);
  assign o_done[0] = done0;
  assign o_done[1] = done1;
  assign o_err[0]  = err0;
  assign o_err[1]  = err1;
  assign o_rdy[0]  = bus0.in_ready;
  assign o_rdy[1]  = bus1.in_ready;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Per-mnemonic tables indexed by op code (0..20).
  // kind: 0=R 1=I-alu 2=shift-imm 3=LW 4=SW 5=branch 6=JAL 7=JALR
  int          kind_t[21] = '{0,0,0,0,0,0,0,0, 1,1,1,1, 2,2,2, 3,4, 5,5, 6,7};
  int          f3_t[21]   = '{0,0,7,6,4,1,5,5, 0,7,6,4, 1,5,5, 2,2, 0,1, 0,0};
  int          alt_t[21]  = '{0,1,0,0,0,0,0,1, 0,0,0,0, 0,0,1, 0,0, 0,0, 0,0};
  int          opc_t[8]   = '{'h33, 'h13, 'h13, 'h03, 'h23, 'h63, 'h6f, 'h67};

  function automatic logic [31:0] ref_enc(int o, logic [31:0] r_d, logic [31:0] r_s1,
                                          logic [31:0] r_s2, logic [31:0] im);
    logic [31:0] w, f3, f7, opc;
    int s;
    bit ok;
    if (o > 20) return 32'h13;
    s   = int'(im);
    ok  = 1'b1;
    f3  = f3_t[o];
    f7  = alt_t[o] ? 32'h20 : 32'h0;
    opc = opc_t[kind_t[o]];
    case (kind_t[o])
      0: w = (f7 << 25) | (r_s2 << 20) | (r_s1 << 15) | (f3 << 12) | (r_d << 7) | opc;
      2: w = (f7 << 25) | ((im & 31) << 20) | (r_s1 << 15) | (f3 << 12) | (r_d << 7) | opc;
      4: w = (((im >> 5) & 'h7f) << 25) | (r_s2 << 20) | (r_s1 << 15) | (f3 << 12)
             | ((im & 31) << 7) | opc;
      5: w = (((im >> 12) & 1) << 31) | (((im >> 5) & 63) << 25) | (r_s2 << 20)
             | (r_s1 << 15) | (f3 << 12) | (((im >> 1) & 15) << 8)
             | (((im >> 11) & 1) << 7) | opc;
      6: w = (((im >> 20) & 1) << 31) | (((im >> 1) & 1023) << 21)
             | (((im >> 11) & 1) << 20) | (((im >> 12) & 255) << 12) | (r_d << 7) | opc;
      default: w = ((im & 'hfff) << 20) | (r_s1 << 15) | (f3 << 12) | (r_d << 7) | opc;
    endcase
`ifdef ENC_RANGE_CHECK_EN
    case (kind_t[o])
      1, 3, 4, 7: ok = (s >= -2048) && (s <= 2047);
      2:          ok = (s >= 0) && (s <= 31);
      5:          ok = (s >= -4096) && (s <= 4094) && (s % 2 == 0);
      6:          ok = (s >= -(1 << 20)) && (s <= (1 << 20) - 2) && (s % 2 == 0);
      default:    ok = 1'b1;
    endcase
`endif
    return ok ? w : 32'h13;
  endfunction

  function automatic bit ref_bad(int o, logic [31:0] im);
    if (o > 20) return 1'b1;
    return (ref_enc(o, 0, 0, 0, im) == 32'h13);
  endfunction

  // Model state per instance: phase 0 idle, 1 loading, 2 flushing, 3 done.
  int          m_ph[2], m_wptr[2], m_cnt[2], m_addr[2];
  bit          m_we[2], m_err[2];
  logic [31:0] m_data[2];

  function automatic int depth(int d);
    return (d == 0) ? 256 : 4;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_ph[d] = 0; m_wptr[d] = 0; m_cnt[d] = 0; m_addr[d] = 0;
      m_we[d] = 0; m_err[d] = 0; m_data[d] = 0;
    end
  endtask

  // One clock cycle: check registered outputs, drive inputs, check ready, advance model.
  task automatic step(bit st, bit v, int o, int a, int b, int c, int im, bit l);
    bit rdy, acc, full;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk_eq($sformatf("d%0d_we", d), 32'(o_we[d]), 32'(m_we[d]));
      if (m_we[d]) begin
        chk_eq($sformatf("d%0d_addr", d), o_addr[d], m_addr[d]);
        chk_eq($sformatf("d%0d_wdata", d), o_data[d], m_data[d]);
      end
      chk_eq($sformatf("d%0d_count", d), o_cnt[d], m_cnt[d]);
      chk_eq($sformatf("d%0d_done", d), 32'(o_done[d]), 32'(m_ph[d] == 3));
      chk_eq($sformatf("d%0d_err", d), 32'(o_err[d]), 32'(m_err[d]));
    end
    start = st; valid = v; op = o[4:0]; rd = a[4:0]; rs1 = b[4:0]; rs2 = c[4:0];
    imm = im; last = l;
    #1;
    for (int d = 0; d < 2; d++) begin
      rdy = (m_ph[d] == 1) && !st;
      chk_eq($sformatf("d%0d_ready", d), 32'(o_rdy[d]), 32'(rdy));
      acc  = v && rdy;
      full = (m_wptr[d] == depth(d) - 1);
      if (st) m_cnt[d] = 0;
      else if (m_we[d] && m_cnt[d] < depth(d)) m_cnt[d]++;
      m_we[d] = acc;
      if (acc) begin
        m_addr[d] = m_wptr[d];
        m_data[d] = ref_enc(o, a, b, c, im);
        if (ref_bad(o, im) || (full && !l)) m_err[d] = 1'b1;
        m_wptr[d] = (m_wptr[d] + 1) % depth(d);
      end
      if (st) begin
        m_err[d] = 1'b0; m_wptr[d] = 0; m_ph[d] = 1;
      end else if (m_ph[d] == 1 && acc && (l || full)) m_ph[d] = 2;
      else if (m_ph[d] == 2) m_ph[d] = 3;
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 0, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    start = 1'b0; valid = 1'b0; last = 1'b0;
    #2 reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk_eq($sformatf("rst_d%0d_we", d), 32'(o_we[d]), 32'h0);
      chk_eq($sformatf("rst_d%0d_addr", d), o_addr[d], 32'h0);
      chk_eq($sformatf("rst_d%0d_wdata", d), o_data[d], 32'h0);
      chk_eq($sformatf("rst_d%0d_count", d), o_cnt[d], 32'h0);
      chk_eq($sformatf("rst_d%0d_done", d), 32'(o_done[d]), 32'h0);
      chk_eq($sformatf("rst_d%0d_err", d), 32'(o_err[d]), 32'h0);
      chk_eq($sformatf("rst_d%0d_ready", d), 32'(o_rdy[d]), 32'h0);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic int rnd_imm();
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(0, 80)) - 40;
      1:       return int'($urandom_range(0, 10000)) - 5000;
      2:       return int'($urandom_range(0, 1 << 22)) - (1 << 21);
      default: return int'($urandom);
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; valid = 1'b0; last = 1'b0;
    op = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
    model_reset();
    do_reset();

    // Directed encodings.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, OpAdd, 3, 1, 2, 0, 0);
    step(0, 1, OpSub, 3, 1, 2, 0, 0);
    chk_eq("add_word", o_data[0], 32'h002081B3);
    chk_eq("add_addr", o_addr[0], 32'd0);
    step(0, 1, OpAddi, 1, 0, 0, -1, 0);
    chk_eq("sub_word", o_data[0], 32'h402081B3);
    chk_eq("sub_addr", o_addr[0], 32'd1);
    step(0, 1, OpLw, 5, 2, 0, 8, 0);
    chk_eq("addi_word", o_data[0], 32'hFFF00093);
    step(0, 1, OpSw, 0, 2, 5, 8, 0);
    chk_eq("lw_word", o_data[0], 32'h00812283);
    step(0, 1, OpBeq, 0, 1, 2, 8, 0);
    chk_eq("sw_word", o_data[0], 32'h00512423);
    step(0, 1, OpAddi, 1, 0, 0, 2048, 0);
    chk_eq("beq_word", o_data[0], 32'h00208463);
    step(0, 1, 31, 1, 2, 3, 0, 1);
`ifdef ENC_RANGE_CHECK_EN
    chk_eq("addi2048_word", o_data[0], 32'h00000013);
    chk_eq("addi2048_err", 32'(err0), 32'h1);
`else
    chk_eq("addi2048_word", o_data[0], 32'h80000093);
    chk_eq("addi2048_err", 32'(err0), 32'h0);
`endif
    idle();
    chk_eq("illegal_word", o_data[0], 32'h00000013);
    chk_eq("done_early", 32'(done0), 32'h0);
    idle();
    chk_eq("illegal_err", 32'(err0), 32'h1);
    chk_eq("done_after_last", 32'(done0), 32'h1);

    // Four back-to-back, last on the fourth.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, OpAdd, i + 1, 1, 2, 0, i == 3);
    idle();
    idle();
    chk_eq("b2b_count", o_cnt[0], 32'd4);
    chk_eq("b2b_done", 32'(done0), 32'h1);

    // Memory full on the ADDR_W=2 instance: five offered, four written.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, OpXor, i, 3, 4, 0, 0);
    idle();
    idle();
    chk_eq("full_err", 32'(err1), 32'h1);
    chk_eq("full_done", 32'(done1), 32'h1);
    chk_eq("full_ready", 32'(bus1.in_ready), 32'h0);
    chk_eq("full_count", o_cnt[1], 32'd4);

    // Restart mid-stream with a write pending.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, OpOr, 1, 2, 3, 0, 0);
    step(0, 1, OpAnd, 1, 2, 3, 0, 0);
    step(1, 1, OpSll, 1, 2, 3, 0, 0);
    step(0, 1, OpSra, 7, 8, 9, 0, 0);
    idle();
    chk_eq("restart_addr", o_addr[0], 32'd0);
    chk_eq("restart_count", o_cnt[0], 32'd0);

    // Reset mid-stream.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, OpJal, 1, 0, 0, 2048, 0);
    step(0, 1, OpJalr, 1, 2, 0, -4, 0);
    do_reset();

    // Randomized programs.
    for (int ld = 0; ld < 8; ld++) begin
      int len;
      step(1, 0, 0, 0, 0, 0, 0, 0);
      len = int'($urandom_range(3, 40));
      for (int i = 0; i < len; i++) begin
        int o;
        repeat ($urandom_range(0, 2))
          step(0, 0, int'($urandom_range(0, 31)), 1, 1, 1, 0, 0);
        if ($urandom_range(0, 60) == 0) step(1, 0, 0, 0, 0, 0, 0, 0);
        o = ($urandom_range(0, 9) == 0) ? int'($urandom_range(21, 31))
                                          : int'($urandom_range(0, 20));
        step(0, 1, o, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
             int'($urandom_range(0, 31)), rnd_imm(), i == len - 1);
      end
      repeat (3) idle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
